lcd_text_sequencer: RTL and testbench

Upstream feeder for the LCD bus-timing stage. Holds a 2x16 character frame buffer written by the application, and streams (rs, byte) pairs to the timing stage over a valid/ready handshake. The stream is the HD44780 init sequence after reset, then DDRAM address commands and frame characters whenever the frame changes or a refresh is requested. The timing stage owns lcd_e, lcd_rw and the bus; this block never touches the pins.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_frame_buf.sv | 30 +++
 rtl/lcd_text_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_lcd_text_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and state type for the LCD text sequencer.
package lcd_pkg;

    // HD44780 commands used by the sequencer
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display (slow on the panel)
    localparam logic [7:0] CMD_LINE1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40

    localparam logic [7:0] CHAR_SPACE   = 8'h20;
    localparam int         FRAME_DEPTH  = 32;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_CLR_WAIT,
        ST_IDLE,
        ST_ADDR1,
        ST_LINE1,
        ST_ADDR2,
        ST_LINE2
    } lcd_state_t;

    // Init command for a given position in the power-up sequence
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_frame_buf.sv
// 2x16 character frame buffer: synchronous write, asynchronous read,
// every entry resets to a space.
module lcd_frame_buf
    import lcd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr_en,
    input  logic [4:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    input  logic [4:0] i_rd_addr,
    output logic [7:0] o_rd_data
);

    logic [7:0] r_mem [FRAME_DEPTH];

    // Store application writes; reset fills the frame with spaces
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FRAME_DEPTH; i++) begin
                r_mem[i] <= CHAR_SPACE;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lcd_text_sequencer.sv
// Streams the HD44780 init sequence, then DDRAM address commands and
// frame characters to the LCD bus-timing stage.
//
// Handshake: a byte moves when out_valid and out_ready are both high on a
// rising edge. While out_valid is high and out_ready low, out_rs/out_data
// hold; out_valid only falls after a transfer (or on reset).
module lcd_text_sequencer
    import lcd_pkg::*;
#(
    parameter int CLEAR_WAIT   = 100000,
    parameter int AUTO_REFRESH = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_rs,
    output logic [7:0] out_data,
    output logic       busy,
    output lcd_state_t dbg_state
);

    // CLR_WAIT lasts CLEAR_WAIT-1 cycles; the single IDLE cycle that follows
    // completes a gap of exactly CLEAR_WAIT cycles with out_valid low.
    localparam int              WAIT_W    = (CLEAR_WAIT > 2) ? $clog2(CLEAR_WAIT - 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (CLEAR_WAIT > 2) ? WAIT_W'(CLEAR_WAIT - 2) : '0;

    lcd_state_t        r_state, w_state_n;
    logic              r_valid, w_valid_n;
    logic              r_rs, w_rs_n;
    logic [7:0]        r_data, w_data_n;
    logic              r_busy, w_busy_n;
    logic              r_dirty, w_dirty_n;
    logic [1:0]        r_init_idx, w_init_idx_n;
    logic [3:0]        r_char_idx, w_char_idx_n;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_n;

    logic              w_xfer;
    logic              w_dirty_clr;
    logic [4:0]        w_rd_addr;
    logic [7:0]        w_rd_data;

    lcd_frame_buf u_frame_buf (
        .i_clk     (clk),
        .i_rst_n   (reset_n),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign w_xfer = r_valid & out_ready;

    // Buffer position of the character that follows the byte now on the output
    assign w_rd_addr = (r_state == ST_ADDR1) ? 5'd0  :
                       (r_state == ST_ADDR2) ? 5'd16 :
                       {(r_state == ST_LINE2), r_char_idx + 4'd1};

    // State, output register and bookkeeping registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_valid    <= 1'b0;
            r_rs       <= 1'b0;
            r_data     <= 8'h00;
            r_busy     <= 1'b1;
            r_dirty    <= 1'b1;
            r_init_idx <= 2'd0;
            r_char_idx <= 4'd0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_n;
            r_valid    <= w_valid_n;
            r_rs       <= w_rs_n;
            r_data     <= w_data_n;
            r_busy     <= w_busy_n;
            r_dirty    <= w_dirty_n;
            r_init_idx <= w_init_idx_n;
            r_char_idx <= w_char_idx_n;
            r_wait_cnt <= w_wait_cnt_n;
        end
    end

    // Next state and next output byte; the next byte is loaded in the
    // transfer cycle so back-to-back bytes need no bubble
    always_comb begin
        w_state_n    = r_state;
        w_valid_n    = r_valid;
        w_rs_n       = r_rs;
        w_data_n     = r_data;
        w_busy_n     = r_busy;
        w_init_idx_n = r_init_idx;
        w_char_idx_n = r_char_idx;
        w_wait_cnt_n = r_wait_cnt;
        w_dirty_clr  = 1'b0;

        case (r_state)
            ST_INIT: begin
                if (!r_valid) begin
                    w_valid_n = 1'b1;
                    w_rs_n    = 1'b0;
                    w_data_n  = init_cmd(r_init_idx);
                end else if (w_xfer) begin
                    if (r_init_idx == 2'd3) begin
                        w_state_n    = ST_CLR_WAIT;
                        w_valid_n    = 1'b0;
                        w_wait_cnt_n = '0;
                    end else begin
                        w_init_idx_n = r_init_idx + 2'd1;
                        w_data_n     = init_cmd(r_init_idx + 2'd1);
                    end
                end
            end
            ST_CLR_WAIT: begin
                if (CLEAR_WAIT <= 2 || r_wait_cnt == WAIT_LAST) begin
                    w_state_n = ST_IDLE;
                    w_busy_n  = 1'b0;
                end else begin
                    w_wait_cnt_n = r_wait_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (r_dirty || refresh || AUTO_REFRESH != 0) begin
                    w_state_n   = ST_ADDR1;
                    w_valid_n   = 1'b1;
                    w_rs_n      = 1'b0;
                    w_data_n    = CMD_LINE1;
                    w_dirty_clr = 1'b1;
                end
            end
            ST_ADDR1: begin
                if (w_xfer) begin
                    w_state_n    = ST_LINE1;
                    w_rs_n       = 1'b1;
                    w_char_idx_n = 4'd0;
                    w_data_n     = w_rd_data;
                end
            end
            ST_LINE1: begin
                if (w_xfer) begin
                    w_char_idx_n = r_char_idx + 4'd1;
                    if (r_char_idx == 4'd15) begin
                        w_state_n = ST_ADDR2;
                        w_rs_n    = 1'b0;
                        w_data_n  = CMD_LINE2;
                    end else begin
                        w_data_n = w_rd_data;
                    end
                end
            end
            ST_ADDR2: begin
                if (w_xfer) begin
                    w_state_n    = ST_LINE2;
                    w_rs_n       = 1'b1;
                    w_char_idx_n = 4'd0;
                    w_data_n     = w_rd_data;
                end
            end
            ST_LINE2: begin
                if (w_xfer) begin
                    w_char_idx_n = r_char_idx + 4'd1;
                    if (r_char_idx == 4'd15) begin
                        w_state_n = ST_IDLE;
                        w_valid_n = 1'b0;
                    end else begin
                        w_data_n = w_rd_data;
                    end
                end
            end
            default: begin
                w_state_n = ST_INIT;
                w_valid_n = 1'b0;
            end
        endcase

        // A write in the same cycle as the scan-start clear keeps dirty set
        w_dirty_n = wr_en | (r_dirty & ~w_dirty_clr);
    end

    assign out_valid = r_valid;
    assign out_rs    = r_rs;
    assign out_data  = r_data;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Directed bench for lcd_text_sequencer: init stream, backpressure,
// dirty/refresh scans, mid-stream reset and auto-refresh cadence.
module tb_lcd_text_sequencer;
    import lcd_pkg::*;

    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       refresh = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_valid, out_rs, busy;
    logic [7:0] out_data;
    lcd_state_t dbg_state;

    logic       a_wr_en = 1'b0;
    logic [4:0] a_wr_addr = '0;
    logic [7:0] a_wr_data = '0;
    logic       a_refresh = 1'b0;
    logic       a_ready = 1'b1;
    logic       a_valid, a_rs, a_busy;
    logic [7:0] a_data;
    lcd_state_t a_dbg_state;

    lcd_text_sequencer #(.CLEAR_WAIT(CW), .AUTO_REFRESH(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .refresh(refresh), .out_valid(out_valid),
        .out_ready(out_ready), .out_rs(out_rs), .out_data(out_data),
        .busy(busy), .dbg_state(dbg_state)
    );

    lcd_text_sequencer #(.CLEAR_WAIT(CW), .AUTO_REFRESH(1)) u_dut_auto (
        .clk(clk), .reset_n(reset_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .refresh(a_refresh), .out_valid(a_valid),
        .out_ready(a_ready), .out_rs(a_rs), .out_data(a_data),
        .busy(a_busy), .dbg_state(a_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rel = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int         got_t[$];
    int         a80_t[$];
    int         a80_n[$];
    int         a_cnt = 0;
    logic [7:0] m_buf[32];
    logic       bp_mode = 1'b0;
    logic       m_pv = 1'b0;
    logic       m_pr = 1'b0;
    logic [8:0] m_pb = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transfer monitor and hold-while-stalled check for the main DUT
    initial forever begin
        @(negedge clk);
        if (reset_n && m_pv && !m_pr) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'({out_rs, out_data}), 32'(m_pb));
        end
        if (out_valid && out_ready) begin
            got_q.push_back({out_rs, out_data});
            got_t.push_back(cyc);
        end
        m_pv = out_valid;
        m_pr = out_ready;
        m_pb = {out_rs, out_data};
    end

    // Line-1 address command timestamps for the auto-refresh DUT
    initial forever begin
        @(negedge clk);
        if (a_valid) begin
            a_cnt++;
            if ({a_rs, a_data} == 9'h080) begin
                a80_t.push_back(cyc);
                a80_n.push_back(a_cnt);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (bp_mode) out_ready = !out_ready;
    endtask

    task automatic write_char(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
        m_buf[a] = d;
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        step();
        refresh = 1'b0;
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, CMD_FUNC_SET});
        exp_q.push_back({1'b0, CMD_DISP_ON});
        exp_q.push_back({1'b0, CMD_ENTRY});
        exp_q.push_back({1'b0, CMD_CLEAR});
    endtask

    task automatic push_scan();
        exp_q.push_back({1'b0, CMD_LINE1});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, m_buf[i]});
        exp_q.push_back({1'b0, CMD_LINE2});
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, m_buf[i]});
    endtask

    task automatic wait_xfers(input int n, input int budget, input string tag);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk({tag, "_arrived"}, 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        int n = exp_q.size();
        chk({tag, "_len"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && got_q.size() > 0; i++) begin
            chk($sformatf("%s[%0d]", tag, i), 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic quiet(input int n, input string tag);
        repeat (n) step();
        chk({tag, "_quiet"}, 32'(got_q.size()), 32'd0);
        got_q.delete();
        got_t.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 32; i++) m_buf[i] = CHAR_SPACE;
        repeat (3) step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rs",    32'(out_rs),    32'd0);
        chk("rst_data",  32'(out_data),  32'h00);
        chk("rst_busy",  32'(busy),      32'd1);
        chk("rst_state", 32'(dbg_state), 32'(ST_INIT));

        // Init sequence, clear gap, then the first scan of spaces
        push_init();
        push_scan();
        reset_n = 1'b1;
        rel = cyc;
        step();
        chk("first_byte", 32'({out_valid, out_rs, out_data}), 32'h238);
        chk("busy_init", 32'(busy), 32'd1);
        wait_xfers(38, 200, "init");
        if (got_t.size() >= 38) begin
            chk("t_0x38", 32'(got_t[0] - rel), 32'd1);
            chk("t_0x01", 32'(got_t[3] - rel), 32'd4);
            chk("t_0x80", 32'(got_t[4] - rel), 32'(4 + CW + 1));
            chk("t_last", 32'(got_t[37] - rel), 32'(4 + CW + 34));
        end
        chk("busy_done", 32'(busy), 32'd0);
        compare_stream("init");
        quiet(10, "init");

        // Auto-refresh: 34-byte scans separated by one IDLE cycle
        for (int k = 0; k < 200 && a80_t.size() < 3; k++) step();
        chk("auto_seen", 32'(a80_t.size() >= 3), 32'd1);
        if (a80_t.size() >= 3) begin
            chk("auto_first", 32'(a80_t[0] - rel), 32'(4 + CW + 1));
            chk("auto_period0", 32'(a80_t[1] - a80_t[0]), 32'd35);
            chk("auto_period1", 32'(a80_t[2] - a80_t[1]), 32'd35);
            chk("auto_len", 32'(a80_n[1] - a80_n[0]), 32'd34);
        end

        // Backpressure: 0x80 stalls while line 1 is written, then ready
        // toggles; the later writes re-dirty the frame so two scans follow
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) write_char(5'(i), 8'(8'h30 + i));
        push_scan();
        push_scan();
        bp_mode = 1'b1;
        wait_xfers(68, 400, "bp");
        bp_mode = 1'b0;
        out_ready = 1'b1;
        compare_stream("bp");
        quiet(20, "bp");

        // 'A' at 0, 'B' at 31 in back-to-back cycles: B coincides with the
        // scan-start dirty clear, so a second scan follows the first
        write_char(5'd0, 8'h41);
        write_char(5'd31, 8'h42);
        push_scan();
        push_scan();
        wait_xfers(68, 300, "ab");
        compare_stream("ab");
        quiet(20, "ab");

        // Refresh in IDLE with dirty clear: exactly one scan, 1-cycle latency
        push_scan();
        pulse_refresh();
        chk("refresh_lat", 32'({out_valid, out_rs, out_data}), 32'h280);
        wait_xfers(34, 100, "refresh");
        compare_stream("refresh");
        quiet(40, "refresh");
        chk("idle_state", 32'(dbg_state), 32'(ST_IDLE));

        // Write to an already-sent position during LINE2: scan finishes
        // with the old byte, then one more scan carries the new one
        push_scan();
        pulse_refresh();
        wait_xfers(20, 100, "l2");
        write_char(5'd2, 8'h5A);
        push_scan();
        wait_xfers(68, 200, "l2");
        compare_stream("l2");
        quiet(40, "l2");

        // Reset mid-LINE1: valid drops without a clock edge, stream restarts
        pulse_refresh();
        wait_xfers(6, 100, "mid");
        chk("mid_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_drop", 32'(out_valid), 32'd0);
        chk("async_state", 32'(dbg_state), 32'(ST_INIT));
        got_q.delete();
        got_t.delete();
        exp_q.delete();
        for (int i = 0; i < 32; i++) m_buf[i] = CHAR_SPACE;
        push_init();
        push_scan();
        step();
        step();
        reset_n = 1'b1;
        rel = cyc;
        wait_xfers(38, 200, "restart");
        if (got_t.size() >= 1) chk("restart_t0", 32'(got_t[0] - rel), 32'd1);
        compare_stream("restart");
        quiet(10, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
